cpu_sequencer: RTL and testbench

Control sequencer for the 8-bit CPU.
- Owns the micro-cycle counter that drives the instruction decoder's `cycle` input.
- Consumes the decoder's `state` output and expands it into the one-hot datapath control strobes.
- Implements run/step/halt control: free-run, single-instruction step, graceful stop at instruction boundary, permanent halt on HLT, and a fault trap for undecodable sequences.
- Sits between the decoder and the datapath (PC, MAR, RAM, IR, A, B, ALU, OUT).

---
 rtl/cpu_sequencer_pkg.sv | 44 ++++
 rtl/cpu_sequencer_ctrl_rom.sv | 55 +++++
 rtl/cpu_sequencer.sv | 98 +++++++++
 tb/tb_cpu_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the 8-bit CPU control path:
// decoder states, opcodes, strobe bit indices and sequencer FSM.
package cpu_sequencer_pkg;

  localparam int CTRL_W = 11;

  localparam logic [3:0] STATE_FETCH_PC   = 4'd0;
  localparam logic [3:0] STATE_FETCH_INST = 4'd1;
  localparam logic [3:0] STATE_FETCH_ARG  = 4'd2;
  localparam logic [3:0] STATE_JUMP_Z     = 4'd3;
  localparam logic [3:0] STATE_LOAD_Z     = 4'd4;
  localparam logic [3:0] STATE_RAM_A      = 4'd5;
  localparam logic [3:0] STATE_RAM_B      = 4'd6;
  localparam logic [3:0] STATE_ALU        = 4'd7;
  localparam logic [3:0] STATE_OUT_A      = 4'd8;
  localparam logic [3:0] STATE_NEXT       = 4'd9;
  localparam logic [3:0] STATE_HALT       = 4'd10;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int C_PC_OE    = 0;
  localparam int C_MAR_LOAD = 1;
  localparam int C_RAM_OE   = 2;
  localparam int C_IR_LOAD  = 3;
  localparam int C_PC_INC   = 4;
  localparam int C_PC_LOAD  = 5;
  localparam int C_Z_LOAD   = 6;
  localparam int C_A_LOAD   = 7;
  localparam int C_B_LOAD   = 8;
  localparam int C_ALU_OE   = 9;
  localparam int C_OUT_LOAD = 10;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_STEP,
    SEQ_HALTED,
    SEQ_FAULT
  } seq_e;

endpackage

// File: rtl/cpu_sequencer_ctrl_rom.sv
// Decoder micro-state to datapath strobe table.
// Pure combinational; NEXT, HALT and unknown codes drive nothing.
module cpu_sequencer_ctrl_rom
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0]        state,
  output logic [CTRL_W-1:0] ctrl
);

  // one entry per micro-state
  always_comb begin
    ctrl = '0;
    unique case (state)
      STATE_FETCH_PC: begin
        ctrl[C_PC_OE]    = 1'b1;
        ctrl[C_MAR_LOAD] = 1'b1;
      end
      STATE_FETCH_INST: begin
        ctrl[C_RAM_OE]  = 1'b1;
        ctrl[C_IR_LOAD] = 1'b1;
        ctrl[C_PC_INC]  = 1'b1;
      end
      STATE_FETCH_ARG: begin
        ctrl[C_RAM_OE]   = 1'b1;
        ctrl[C_MAR_LOAD] = 1'b1;
        ctrl[C_PC_INC]   = 1'b1;
      end
      STATE_JUMP_Z: begin
        ctrl[C_RAM_OE]  = 1'b1;
        ctrl[C_PC_LOAD] = 1'b1;
      end
      STATE_LOAD_Z: begin
        ctrl[C_RAM_OE] = 1'b1;
        ctrl[C_Z_LOAD] = 1'b1;
      end
      STATE_RAM_A: begin
        ctrl[C_RAM_OE] = 1'b1;
        ctrl[C_A_LOAD] = 1'b1;
      end
      STATE_RAM_B: begin
        ctrl[C_RAM_OE] = 1'b1;
        ctrl[C_B_LOAD] = 1'b1;
      end
      STATE_ALU: begin
        ctrl[C_ALU_OE] = 1'b1;
        ctrl[C_A_LOAD] = 1'b1;
      end
      STATE_OUT_A: begin
        ctrl[C_OUT_LOAD] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Micro-cycle sequencer with run/step/halt control.
// Strobes are gated by a registered exec flag so reset silences them.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CYCLE_W   = 4,
  parameter int MAX_CYCLE = 7,
  parameter int AUTO_RUN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  output logic [CYCLE_W-1:0] cycle,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               instr_done,
  output logic               idle,
  output logic               halted,
  output logic               fault
);

  localparam seq_e RST_ST = (AUTO_RUN != 0) ? SEQ_RUN : SEQ_IDLE;
  localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(MAX_CYCLE);

  seq_e               fsm_q, fsm_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic               exec_q, exec_d;
  logic [CTRL_W-1:0]  rom_ctrl;

  cpu_sequencer_ctrl_rom u_ctrl_rom (
    .state (state),
    .ctrl  (rom_ctrl)
  );

  // next state: IDLE start, per-cycle retire/halt/fault priority
  always_comb begin
    fsm_d   = fsm_q;
    cycle_d = cycle_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      SEQ_IDLE: begin
        if (step_req)     fsm_d = SEQ_STEP;
        else if (run_req) fsm_d = SEQ_RUN;
      end
      SEQ_RUN, SEQ_STEP: begin
        if (exec_q) begin
          if (fsm_q == SEQ_RUN && halt_req) pend_d = 1'b1;
          if (state == STATE_HALT) begin
            fsm_d = SEQ_HALTED;
          end else if (state == STATE_NEXT) begin
            cycle_d = '0;
            done_d  = 1'b1;
            if (fsm_q == SEQ_STEP || pend_d) begin
              fsm_d  = SEQ_IDLE;
              pend_d = 1'b0;
            end
          end else if (cycle_q == LAST) begin
            fsm_d = SEQ_FAULT;
          end else begin
            cycle_d = cycle_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    exec_d = (fsm_d == SEQ_RUN) || (fsm_d == SEQ_STEP);
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= RST_ST;
      cycle_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cycle_q <= cycle_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      exec_q  <= exec_d;
    end
  end

  assign cycle      = cycle_q;
  assign ctrl       = exec_q ? rom_ctrl : '0;
  assign instr_done = done_q;
  assign idle       = (fsm_q == SEQ_IDLE);
  assign halted     = (fsm_q == SEQ_HALTED);
  assign fault      = (fsm_q == SEQ_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one AUTO_RUN=0 and one
// AUTO_RUN=1 instance, each driven by a small decoder stub.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam logic [3:0] OP_BAD = 4'h7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  logic        a_reset, a_run, a_step, a_halt;
  logic [3:0]  a_op, a_state, a_cycle;
  logic [10:0] a_ctrl;
  logic        a_done, a_idle, a_halted, a_fault;

  logic        b_reset, b_run, b_step, b_halt;
  logic [3:0]  b_op, b_state, b_cycle;
  logic [10:0] b_ctrl;
  logic        b_done, b_idle, b_halted, b_fault;

  function automatic logic [3:0] stub(input logic [3:0] op,
                                      input logic [3:0] cyc);
    logic [3:0] s;
    s = 4'hF;
    case (op)
      OP_OUT:
        case (cyc)
          4'd0: s = STATE_FETCH_PC;
          4'd1: s = STATE_FETCH_INST;
          4'd2: s = STATE_OUT_A;
          4'd3: s = STATE_NEXT;
          default: s = 4'hF;
        endcase
      OP_LDA:
        case (cyc)
          4'd0: s = STATE_FETCH_PC;
          4'd1: s = STATE_FETCH_INST;
          4'd2: s = STATE_FETCH_PC;
          4'd3: s = STATE_FETCH_ARG;
          4'd4: s = STATE_FETCH_ARG;
          4'd5: s = STATE_RAM_A;
          4'd6: s = STATE_NEXT;
          default: s = 4'hF;
        endcase
      OP_ADD:
        case (cyc)
          4'd0: s = STATE_FETCH_PC;
          4'd1: s = STATE_FETCH_INST;
          4'd2: s = STATE_FETCH_PC;
          4'd3: s = STATE_FETCH_ARG;
          4'd4: s = STATE_FETCH_ARG;
          4'd5: s = STATE_RAM_B;
          4'd6: s = STATE_ALU;
          4'd7: s = STATE_NEXT;
          default: s = 4'hF;
        endcase
      OP_HLT:
        case (cyc)
          4'd0: s = STATE_FETCH_PC;
          4'd1: s = STATE_FETCH_INST;
          4'd2: s = STATE_HALT;
          default: s = 4'hF;
        endcase
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  assign a_state = stub(a_op, a_cycle);
  assign b_state = stub(b_op, b_cycle);

  cpu_sequencer #(.CYCLE_W(4), .MAX_CYCLE(7), .AUTO_RUN(0)) u_dut_a (
    .clk        (clk),
    .reset      (a_reset),
    .state      (a_state),
    .cycle      (a_cycle),
    .run_req    (a_run),
    .step_req   (a_step),
    .halt_req   (a_halt),
    .ctrl       (a_ctrl),
    .instr_done (a_done),
    .idle       (a_idle),
    .halted     (a_halted),
    .fault      (a_fault)
  );

  cpu_sequencer #(.CYCLE_W(4), .MAX_CYCLE(7), .AUTO_RUN(1)) u_dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .state      (b_state),
    .cycle      (b_cycle),
    .run_req    (b_run),
    .step_req   (b_step),
    .halt_req   (b_halt),
    .ctrl       (b_ctrl),
    .instr_done (b_done),
    .idle       (b_idle),
    .halted     (b_halted),
    .fault      (b_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b0; b_reset = 1'b0;
    a_run = 0; a_step = 0; a_halt = 0;
    b_run = 0; b_step = 0; b_halt = 0;
    a_op = OP_OUT; b_op = OP_LDA;
    #12;
    vec++; if (a_cycle !== 4'd0) begin miss++;
      $display("FAIL rst_a_cycle got %0h want 0", a_cycle); end
    vec++; if (a_ctrl !== 11'h000) begin miss++;
      $display("FAIL rst_a_ctrl got %0h want 0", a_ctrl); end
    vec++; if ({a_idle, a_halted, a_fault, a_done} !== 4'b1000) begin
      miss++; $display("FAIL rst_a_flags got %b want 1000",
        {a_idle, a_halted, a_fault, a_done}); end
    vec++; if (b_ctrl !== 11'h000) begin miss++;
      $display("FAIL rst_b_ctrl got %0h want 0", b_ctrl); end
    vec++; if ({b_idle, b_halted, b_fault, b_done} !== 4'b0000) begin
      miss++; $display("FAIL rst_b_flags got %b want 0000",
        {b_idle, b_halted, b_fault, b_done}); end
    a_reset = 1'b1; b_reset = 1'b1;
    tick();
    vec++; if (a_idle !== 1'b1 || a_ctrl !== 11'h000) begin miss++;
      $display("FAIL post_rst_a_idle got %b/%0h want 1/0",
        a_idle, a_ctrl); end
  endtask

  task automatic test_step();
    logic [10:0] exp_c [4] = '{11'h003, 11'h01C, 11'h400, 11'h000};
    a_op = OP_OUT;
    a_step = 1'b1;
    tick();
    a_step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++; if (a_cycle !== 4'(i) || a_ctrl !== exp_c[i] ||
                 a_idle !== 1'b0 || a_done !== 1'b0) begin miss++;
        $display("FAIL step_c%0d got cyc=%0h ctrl=%0h idle=%b done=%b want cyc=%0h ctrl=%0h idle=0 done=0",
          i, a_cycle, a_ctrl, a_idle, a_done, i, exp_c[i]); end
      tick();
    end
    vec++; if (a_cycle !== 4'd0 || a_done !== 1'b1 ||
               a_idle !== 1'b1 || a_ctrl !== 11'h000) begin miss++;
      $display("FAIL step_end got cyc=%0h done=%b idle=%b ctrl=%0h want 0/1/1/0",
        a_cycle, a_done, a_idle, a_ctrl); end
    tick();
    vec++; if (a_done !== 1'b0 || a_idle !== 1'b1 || a_cycle !== 4'd0)
    begin miss++;
      $display("FAIL step_after got done=%b idle=%b cyc=%0h want 0/1/0",
        a_done, a_idle, a_cycle); end
  endtask

  task automatic test_step_priority();
    a_run = 1'b1; a_step = 1'b1;
    tick();
    a_run = 1'b0; a_step = 1'b0;
    repeat (4) tick();
    vec++; if (a_idle !== 1'b1 || a_done !== 1'b1 || a_cycle !== 4'd0)
    begin miss++;
      $display("FAIL step_wins got idle=%b done=%b cyc=%0h want 1/1/0",
        a_idle, a_done, a_cycle); end
  endtask

  task automatic test_run_halt_same_edge();
    a_halt = 1'b1;
    tick();
    a_halt = 1'b0;
    vec++; if (a_idle !== 1'b1 || a_cycle !== 4'd0 || a_ctrl !== 11'h000)
    begin miss++;
      $display("FAIL idle_halt_ign got idle=%b cyc=%0h ctrl=%0h want 1/0/0",
        a_idle, a_cycle, a_ctrl); end
    a_run = 1'b1;
    tick();
    a_run = 1'b0;
    vec++; if (a_ctrl !== 11'h003 || a_idle !== 1'b0) begin miss++;
      $display("FAIL run_start got ctrl=%0h idle=%b want 003/0",
        a_ctrl, a_idle); end
    repeat (4) tick();
    vec++; if (a_done !== 1'b1 || a_idle !== 1'b0 || a_cycle !== 4'd0)
    begin miss++;
      $display("FAIL run_keeps got done=%b idle=%b cyc=%0h want 1/0/0",
        a_done, a_idle, a_cycle); end
    repeat (3) tick();
    vec++; if (a_cycle !== 4'd3) begin miss++;
      $display("FAIL run_c3 got %0h want 3", a_cycle); end
    a_halt = 1'b1;
    tick();
    a_halt = 1'b0;
    vec++; if (a_done !== 1'b1 || a_idle !== 1'b1 || a_cycle !== 4'd0)
    begin miss++;
      $display("FAIL halt_next_edge got done=%b idle=%b cyc=%0h want 1/1/0",
        a_done, a_idle, a_cycle); end
  endtask

  task automatic test_run_lda_reset();
    logic [10:0] exp_c [7] = '{11'h003, 11'h01C, 11'h003, 11'h016,
                               11'h016, 11'h084, 11'h000};
    b_op = OP_LDA;
    b_reset = 1'b0;
    #2;
    b_reset = 1'b1;
    vec++; if (b_ctrl !== 11'h000) begin miss++;
      $display("FAIL b_rel_ctrl got %0h want 0", b_ctrl); end
    tick();
    for (int i = 0; i < 7; i++) begin
      vec++; if (b_cycle !== 4'(i) || b_ctrl !== exp_c[i] ||
                 b_done !== 1'b0) begin miss++;
        $display("FAIL lda_c%0d got cyc=%0h ctrl=%0h done=%b want cyc=%0h ctrl=%0h done=0",
          i, b_cycle, b_ctrl, b_done, i, exp_c[i]); end
      tick();
    end
    vec++; if (b_cycle !== 4'd0 || b_done !== 1'b1 || b_idle !== 1'b0 ||
               b_ctrl !== 11'h003) begin miss++;
      $display("FAIL lda_wrap got cyc=%0h done=%b idle=%b ctrl=%0h want 0/1/0/003",
        b_cycle, b_done, b_idle, b_ctrl); end
    repeat (5) tick();
    vec++; if (b_cycle !== 4'd5 || b_ctrl !== 11'h084) begin miss++;
      $display("FAIL lda2_c5 got cyc=%0h ctrl=%0h want 5/084",
        b_cycle, b_ctrl); end
    #2;
    b_reset = 1'b0;
    #1;
    vec++; if (b_cycle !== 4'd0 || b_ctrl !== 11'h000) begin miss++;
      $display("FAIL async_rst got cyc=%0h ctrl=%0h want 0/0",
        b_cycle, b_ctrl); end
    #1;
    b_reset = 1'b1;
    tick();
    vec++; if (b_cycle !== 4'd0 || b_ctrl !== 11'h003 || b_idle !== 1'b0)
    begin miss++;
      $display("FAIL rst_resume got cyc=%0h ctrl=%0h idle=%b want 0/003/0",
        b_cycle, b_ctrl, b_idle); end
    tick();
    vec++; if (b_cycle !== 4'd1) begin miss++;
      $display("FAIL rst_resume_c1 got %0h want 1", b_cycle); end
  endtask

  task automatic test_halt_req_add();
    repeat (6) tick();
    vec++; if (b_cycle !== 4'd0 || b_done !== 1'b1) begin miss++;
      $display("FAIL lda3_end got cyc=%0h done=%b want 0/1",
        b_cycle, b_done); end
    b_op = OP_ADD;
    repeat (4) tick();
    b_halt = 1'b1;
    tick();
    b_halt = 1'b0;
    vec++; if (b_cycle !== 4'd5 || b_ctrl !== 11'h104 || b_idle !== 1'b0)
    begin miss++;
      $display("FAIL add_c5 got cyc=%0h ctrl=%0h idle=%b want 5/104/0",
        b_cycle, b_ctrl, b_idle); end
    tick();
    vec++; if (b_cycle !== 4'd6 || b_ctrl !== 11'h280) begin miss++;
      $display("FAIL add_c6 got cyc=%0h ctrl=%0h want 6/280",
        b_cycle, b_ctrl); end
    tick();
    vec++; if (b_cycle !== 4'd7 || b_fault !== 1'b0 || b_idle !== 1'b0)
    begin miss++;
      $display("FAIL add_c7 got cyc=%0h fault=%b idle=%b want 7/0/0",
        b_cycle, b_fault, b_idle); end
    tick();
    vec++; if (b_cycle !== 4'd0 || b_done !== 1'b1 || b_idle !== 1'b1 ||
               b_ctrl !== 11'h000 || b_fault !== 1'b0) begin miss++;
      $display("FAIL add_stop got cyc=%0h done=%b idle=%b ctrl=%0h fault=%b want 0/1/1/0/0",
        b_cycle, b_done, b_idle, b_ctrl, b_fault); end
    tick();
    vec++; if (b_idle !== 1'b1 || b_done !== 1'b0 || b_cycle !== 4'd0)
    begin miss++;
      $display("FAIL add_idle got idle=%b done=%b cyc=%0h want 1/0/0",
        b_idle, b_done, b_cycle); end
    b_run = 1'b1;
    tick();
    b_run = 1'b0;
    vec++; if (b_cycle !== 4'd0 || b_ctrl !== 11'h003 || b_idle !== 1'b0)
    begin miss++;
      $display("FAIL resume got cyc=%0h ctrl=%0h idle=%b want 0/003/0",
        b_cycle, b_ctrl, b_idle); end
  endtask

  task automatic test_hlt();
    b_op = OP_HLT;
    tick();
    vec++; if (b_cycle !== 4'd1 || b_ctrl !== 11'h01C) begin miss++;
      $display("FAIL hlt_c1 got cyc=%0h ctrl=%0h want 1/01C",
        b_cycle, b_ctrl); end
    tick();
    vec++; if (b_cycle !== 4'd2 || b_ctrl !== 11'h000 || b_halted !== 1'b0)
    begin miss++;
      $display("FAIL hlt_c2 got cyc=%0h ctrl=%0h halted=%b want 2/0/0",
        b_cycle, b_ctrl, b_halted); end
    tick();
    vec++; if (b_halted !== 1'b1 || b_cycle !== 4'd2 || b_ctrl !== 11'h000)
    begin miss++;
      $display("FAIL hlt_stop got halted=%b cyc=%0h ctrl=%0h want 1/2/0",
        b_halted, b_cycle, b_ctrl); end
    b_run = 1'b1; b_step = 1'b1;
    tick();
    tick();
    b_run = 1'b0; b_step = 1'b0;
    vec++; if (b_halted !== 1'b1 || b_cycle !== 4'd2 || b_idle !== 1'b0 ||
               b_ctrl !== 11'h000) begin miss++;
      $display("FAIL hlt_sticky got halted=%b cyc=%0h idle=%b ctrl=%0h want 1/2/0/0",
        b_halted, b_cycle, b_idle, b_ctrl); end
    b_reset = 1'b0;
    #1;
    vec++; if (b_halted !== 1'b0 || b_cycle !== 4'd0) begin miss++;
      $display("FAIL hlt_rst got halted=%b cyc=%0h want 0/0",
        b_halted, b_cycle); end
    b_op = OP_BAD;
    #1;
    b_reset = 1'b1;
  endtask

  task automatic test_fault();
    tick();
    for (int i = 0; i < 7; i++) begin
      vec++; if (b_cycle !== 4'(i) || b_ctrl !== 11'h000 ||
                 b_fault !== 1'b0) begin miss++;
        $display("FAIL bad_c%0d got cyc=%0h ctrl=%0h fault=%b want %0h/0/0",
          i, b_cycle, b_ctrl, b_fault, i); end
      tick();
    end
    vec++; if (b_cycle !== 4'd7 || b_fault !== 1'b0) begin miss++;
      $display("FAIL bad_c7 got cyc=%0h fault=%b want 7/0",
        b_cycle, b_fault); end
    tick();
    vec++; if (b_fault !== 1'b1 || b_cycle !== 4'd7 || b_ctrl !== 11'h000)
    begin miss++;
      $display("FAIL fault got fault=%b cyc=%0h ctrl=%0h want 1/7/0",
        b_fault, b_cycle, b_ctrl); end
    b_run = 1'b1;
    tick();
    b_run = 1'b0;
    tick();
    vec++; if (b_fault !== 1'b1 || b_cycle !== 4'd7 || b_idle !== 1'b0)
    begin miss++;
      $display("FAIL fault_sticky got fault=%b cyc=%0h idle=%b want 1/7/0",
        b_fault, b_cycle, b_idle); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_step_priority();
    test_run_halt_same_edge();
    test_run_lda_reset();
    test_halt_req_add();
    test_hlt();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
